countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_if.sv | 20 ++
 rtl/countdown_timer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// Control and display bundle for the MM:SS.FF countdown timer.
// The master drives the start/load controls and the slave (the timer) drives the display outputs.
interface countdown_timer_if;
  logic        start;
  logic        load;
  logic [23:0] preset;
  logic [23:0] digits;
  logic        running;
  logic        alarm;

  modport master (
    output start, load, preset,
    input  digits, running, alarm
  );

  modport slave (
    input  start, load, preset,
    output digits, running, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD countdown timer (MM:SS.FF) with a run/pause toggle, preset load and expiry alarm.
// A prescaler divides clk down to 0.01 s ticks.
module countdown_timer #(
  parameter int TICK_DIV = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST_COUNT = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;

  state_e          state_q, state_d;
  logic [23:0]     digits_q, digits_d;
  logic [PW-1:0]   prescale_q, prescale_d;
  logic            running_q, running_d;
  logic            alarm_q, alarm_d;

  logic            load_ok;
  logic            tick;
  logic [23:0]     dec_digits;

  // Minutes and seconds tens digits only go to 5; every other digit goes to 9.
  function automatic logic preset_valid(input logic [23:0] p);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (p[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (p[23:20] > 4'd5 || p[15:12] > 4'd5) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [23:0] bcd_dec(input logic [23:0] d);
    logic [23:0] r;
    logic        borrow;
    r      = d;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = (i == 3 || i == 5) ? 4'd5 : 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    prescale_d = prescale_q;
    load_ok    = bus.load && preset_valid(bus.preset);
    tick       = (prescale_q == LAST_COUNT);
    dec_digits = bcd_dec(digits_q);

    case (state_q)
      IDLE: begin
        if (load_ok) begin
          digits_d = bus.preset;
        end else if (bus.start && digits_q != '0) begin
          state_d    = RUN;
          prescale_d = '0;
        end
      end
      // The prescaler advances on every RUN cycle, including the one that pauses.
      RUN: begin
        if (tick) begin
          prescale_d = '0;
          digits_d   = dec_digits;
        end else begin
          prescale_d = prescale_q + PW'(1);
        end
        if (tick && dec_digits == '0) begin
          state_d = EXPIRED;
        end else if (bus.start) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (load_ok) begin
          digits_d = bus.preset;
          state_d  = IDLE;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end
      EXPIRED: begin
        digits_d = '0;
        if (load_ok) begin
          digits_d = bus.preset;
          state_d  = IDLE;
        end else if (bus.start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    running_d = (state_d == RUN);
    alarm_d   = (state_d == EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      digits_q   <= '0;
      prescale_q <= '0;
      running_q  <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      prescale_q <= prescale_d;
      running_q  <= running_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bus.digits  = digits_q;
  assign bus.running = running_q;
  assign bus.alarm   = alarm_q;

endmodule
